// File: rtl/char_anim_pkg.sv
// char_anim_pkg: shared encodings for the character animation sequencer
package char_anim_pkg;
   localparam int ID_W = 4;
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LEFT      = 3'd1,
      ST_RIGHT     = 3'd2,
      ST_CHARGE    = 3'd3,
      ST_JUMP      = 3'd4,
      ST_COLLISION = 3'd5,
      ST_FALL      = 3'd6,
      ST_HOLD      = 3'd7
   } char_state_t;
   localparam logic [ID_W-1:0] ID_IDLE_A    = 4'd0;
   localparam logic [ID_W-1:0] ID_IDLE_B    = 4'd1;
   localparam logic [ID_W-1:0] ID_WALK_A    = 4'd2;
   localparam logic [ID_W-1:0] ID_WALK_B    = 4'd3;
   localparam logic [ID_W-1:0] ID_CHARGE    = 4'd4;
   localparam logic [ID_W-1:0] ID_JUMP_UP   = 4'd5;
   localparam logic [ID_W-1:0] ID_JUMP_DOWN = 4'd6;
   localparam logic [ID_W-1:0] ID_HARD_LAND = 4'd7;
   localparam logic [ID_W-1:0] ID_SOFT_LAND = 4'd8;
   function automatic logic is_land(input logic [ID_W-1:0] id);
      return id == ID_HARD_LAND || id == ID_SOFT_LAND;
   endfunction
   function automatic logic is_walk(input logic [ID_W-1:0] id);
      return id == ID_WALK_A || id == ID_WALK_B;
   endfunction
endpackage

// File: rtl/char_anim_if.sv
// char_anim_if: physics-side bundle into and sprite-side results out of the sequencer
interface char_anim_if
   import char_anim_pkg::*;
#(
   parameter int SIGNED_PHY_WIDTH = 17
);
   logic                               frame_tick;
   char_state_t                        char_state;
   logic signed [SIGNED_PHY_WIDTH-1:0] vel_y;
   logic [ID_W-1:0]                    char_display_id;
   logic                               mirror;
   logic                               anim_busy;
   logic                               hard_land;
   modport master (
      output frame_tick, char_state, vel_y,
      input  char_display_id, mirror, anim_busy, hard_land
   );
   modport slave (
      input  frame_tick, char_state, vel_y,
      output char_display_id, mirror, anim_busy, hard_land
   );
endinterface

// File: rtl/char_anim_tick_counter.sv
// char_anim_tick_counter: modulo counter that either wraps or saturates at MOD-1, with clear priority
module char_anim_tick_counter #(
   parameter int WIDTH = 7,
   parameter int MOD   = 64,
   parameter bit SAT   = 1'b0
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
   // count on enable, clear wins, wrap or hold at the last value
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= (cnt == LAST) ? (SAT ? cnt : '0) : cnt + 1'b1;
endmodule

// File: rtl/char_anim_sequencer.sv
// char_anim_sequencer: maps physics state and vertical velocity to a sprite frame id per display tick
module char_anim_sequencer
   import char_anim_pkg::*;
#(
   parameter int SIGNED_PHY_WIDTH = 17,
   parameter int REFRESH_RATE     = 64,
   parameter int BREATHE_TICKS    = 32,
   parameter int WALK_TICKS       = 8,
   parameter int LAND_TICKS       = 64,
   parameter int HARD_FALL_VEL    = 2,
   parameter int CNT_W            = $clog2(REFRESH_RATE + 1)
) (
   input logic        sys_clk,
   input logic        sys_rst_n,
   char_anim_if.slave bus
);
   localparam logic signed [SIGNED_PHY_WIDTH-1:0] HARD_NEG = -SIGNED_PHY_WIDTH'(HARD_FALL_VEL);
   localparam logic [CNT_W-1:0] BREATHE_T = CNT_W'(BREATHE_TICKS);
   localparam logic [CNT_W-1:0] WALK_T    = CNT_W'(WALK_TICKS);
   localparam logic [CNT_W-1:0] LAND_LAST = CNT_W'(LAND_TICKS - 1);
   logic                               tick_d;
   char_state_t                        st_d;
   logic signed [SIGNED_PHY_WIDTH-1:0] vy_d;
   logic signed [SIGNED_PHY_WIDTH-1:0] vel_prev;
   logic [ID_W-1:0]                    id;
   logic [ID_W-1:0]                    next_id;
   logic                               fresh_land;
   logic                               mirror_q;
   logic                               busy_q;
   logic                               hard_q;
   logic [CNT_W-1:0]                   phase_cnt;
   logic [CNT_W-1:0]                   walk_cnt;
   logic [CNT_W-1:0]                   hold_cnt;
   logic                               vy_pos;
   logic                               vy_neg;
   assign vy_neg = vy_d[SIGNED_PHY_WIDTH-1];
   assign vy_pos = !vy_neg && vy_d != '0;
   // register the physics inputs so everything downstream sees one consistent sample
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         tick_d <= 1'b0;
         st_d   <= ST_IDLE;
         vy_d   <= '0;
      end else begin
         tick_d <= bus.frame_tick;
         st_d   <= bus.char_state;
         vy_d   <= bus.vel_y;
      end
   // frame selection by priority; fresh_land flags a new touchdown so the hold timer restarts
   always_comb begin
      next_id    = id;
      fresh_land = 1'b0;
      if (st_d == ST_CHARGE) next_id = ID_CHARGE;
      else if (is_land(id) && hold_cnt < LAND_LAST) next_id = id;
      else if (st_d == ST_FALL) begin
         if (vel_prev != '0) begin
            next_id    = (vel_prev < HARD_NEG) ? ID_HARD_LAND : ID_SOFT_LAND;
            fresh_land = 1'b1;
         end
      end
      else if (vy_pos) next_id = ID_JUMP_UP;
      else if (vy_neg) next_id = ID_JUMP_DOWN;
      else if (st_d == ST_LEFT || st_d == ST_RIGHT) next_id = (walk_cnt < WALK_T) ? ID_WALK_A : ID_WALK_B;
      else if (st_d == ST_IDLE) next_id = (phase_cnt < BREATHE_T) ? ID_IDLE_A : ID_IDLE_B;
   end
   // frame id, facing, busy flag and the one-clock hard landing strobe
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         id       <= ID_IDLE_A;
         mirror_q <= 1'b0;
         busy_q   <= 1'b0;
         hard_q   <= 1'b0;
         vel_prev <= '0;
      end else begin
         hard_q <= tick_d && next_id == ID_HARD_LAND && id != ID_HARD_LAND;
         if (tick_d) begin
            id       <= next_id;
            busy_q   <= is_land(next_id);
            vel_prev <= vy_d;
            mirror_q <= (st_d == ST_LEFT) ? 1'b1 : (st_d == ST_RIGHT) ? 1'b0 : mirror_q;
         end
      end
   char_anim_tick_counter #(.WIDTH(CNT_W), .MOD(REFRESH_RATE), .SAT(1'b0)) u_phase (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .en       (tick_d),
      .clr      (1'b0),
      .cnt      (phase_cnt)
   );
   char_anim_tick_counter #(.WIDTH(CNT_W), .MOD(2 * WALK_TICKS), .SAT(1'b0)) u_walk (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .en       (tick_d),
      .clr      (tick_d && !is_walk(next_id)),
      .cnt      (walk_cnt)
   );
   char_anim_tick_counter #(.WIDTH(CNT_W), .MOD(LAND_TICKS), .SAT(1'b1)) u_hold (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .en       (tick_d),
      .clr      (tick_d && (!is_land(id) || !is_land(next_id) || fresh_land)),
      .cnt      (hold_cnt)
   );
   assign bus.char_display_id = id;
   assign bus.mirror          = mirror_q;
   assign bus.anim_busy       = busy_q;
   assign bus.hard_land       = hard_q;
endmodule

// File: tb/tb_char_anim_sequencer.sv
// tb_char_anim_sequencer: directed vector table plus hand sequences for the animation sequencer
module tb_char_anim_sequencer;
   import char_anim_pkg::*;
   localparam int PW = 17;
   logic sys_clk;
   logic sys_rst_n;
   int   n_chk;
   int   n_err;
   char_anim_if #(.SIGNED_PHY_WIDTH(PW)) bus ();
   char_anim_sequencer #(.SIGNED_PHY_WIDTH(PW)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus)
   );
   typedef struct {
      char_state_t st;
      int          vy;
      int          id;
      int          m;
      int          b;
      int          h;
   } vec_t;
   vec_t tv[21];
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask
   task automatic chk_out(input string nm, input int id, input int m, input int b, input int h);
      chk({nm, " id"}, 32'(bus.char_display_id), id);
      chk({nm, " mirror"}, 32'(bus.mirror), m);
      chk({nm, " busy"}, 32'(bus.anim_busy), b);
      chk({nm, " hard_land"}, 32'(bus.hard_land), h);
   endtask
   task automatic do_reset();
      sys_rst_n      = 1'b0;
      bus.frame_tick = 1'b0;
      bus.char_state = ST_IDLE;
      bus.vel_y      = '0;
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
   endtask
   task automatic tick(input char_state_t st, input int vy);
      bus.char_state = st;
      bus.vel_y      = PW'(vy);
      bus.frame_tick = 1'b1;
      @(posedge sys_clk);
      #1 bus.frame_tick = 1'b0;
      @(posedge sys_clk);
      #1;
   endtask
   initial begin
      int busy_n;
      int hl_n;
      n_chk = 0;
      n_err = 0;
      tv[0]  = '{ST_RIGHT,     0, 2, 0, 0, 0};
      tv[1]  = '{ST_LEFT,      0, 2, 1, 0, 0};
      tv[2]  = '{ST_JUMP,      5, 5, 1, 0, 0};
      tv[3]  = '{ST_JUMP,      5, 5, 1, 0, 0};
      tv[4]  = '{ST_COLLISION,-7, 6, 1, 0, 0};
      tv[5]  = '{ST_HOLD,      0, 6, 1, 0, 0};
      tv[6]  = '{ST_FALL,      0, 6, 1, 0, 0};
      tv[7]  = '{ST_JUMP,     -2, 6, 1, 0, 0};
      tv[8]  = '{ST_FALL,      0, 8, 1, 1, 0};
      tv[9]  = '{ST_CHARGE,    0, 4, 1, 0, 0};
      tv[10] = '{ST_IDLE,      0, 0, 1, 0, 0};
      tv[11] = '{ST_HOLD,      1, 5, 1, 0, 0};
      tv[12] = '{ST_RIGHT,     0, 2, 0, 0, 0};
      tv[13] = '{ST_LEFT,      0, 2, 1, 0, 0};
      tv[14] = '{ST_FALL,      4, 2, 1, 0, 0};
      tv[15] = '{ST_FALL,      0, 8, 1, 1, 0};
      tv[16] = '{ST_CHARGE,    0, 4, 1, 0, 0};
      tv[17] = '{ST_RIGHT,     0, 2, 0, 0, 0};
      tv[18] = '{ST_JUMP,     -3, 6, 0, 0, 0};
      tv[19] = '{ST_FALL,      0, 7, 0, 1, 1};
      tv[20] = '{ST_FALL,      0, 7, 0, 1, 0};
      do_reset();
      chk_out("reset", 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         tick(ST_IDLE, 0);
         chk_out($sformatf("idle%0d", i), ((i % 64) < 32) ? 0 : 1, 0, 0, 0);
      end
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick(ST_LEFT, 0);
         chk_out($sformatf("walk%0d", i), (i < 8 || i >= 16) ? 2 : 3, 1, 0, 0);
      end
      tick(ST_RIGHT, 0);
      chk_out("walk_right", 2, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 21; i++) begin
         tick(tv[i].st, tv[i].vy);
         chk_out($sformatf("vec%0d", i), tv[i].id, tv[i].m, tv[i].b, tv[i].h);
      end
      do_reset();
      tick(ST_JUMP, 5);
      tick(ST_JUMP, 5);
      chk_out("air_up", 5, 0, 0, 0);
      tick(ST_JUMP, -7);
      tick(ST_JUMP, -7);
      chk_out("air_down", 6, 0, 0, 0);
      tick(ST_FALL, 0);
      chk_out("hard_entry", 7, 0, 1, 1);
      @(posedge sys_clk);
      #1 chk("hard_pulse_width", 32'(bus.hard_land), 0);
      busy_n = 1;
      hl_n   = 0;
      for (int i = 0; i < 70; i++) begin
         tick(ST_IDLE, 0);
         busy_n += 32'(bus.anim_busy);
         hl_n   += 32'(bus.hard_land);
         if (i < 63) chk($sformatf("hard_hold%0d id", i), 32'(bus.char_display_id), 7);
         if (i == 63) chk_out("hard_exit", 0, 0, 0, 0);
      end
      chk("hard_busy_ticks", busy_n, 64);
      chk("hard_extra_pulses", hl_n, 0);
      do_reset();
      tick(ST_JUMP, -1);
      chk_out("soft_air", 6, 0, 0, 0);
      tick(ST_FALL, 0);
      chk_out("soft_entry", 8, 0, 1, 0);
      for (int i = 1; i < 10; i++) begin
         tick(ST_IDLE, 0);
         chk_out($sformatf("soft_hold%0d", i), 8, 0, 1, 0);
      end
      tick(ST_CHARGE, 0);
      chk_out("soft_abort", 4, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         bus.char_state = (i % 2 == 0) ? ST_LEFT : ST_FALL;
         bus.vel_y      = PW'((i % 2 == 0) ? 3 : -9);
         @(posedge sys_clk);
         #1 chk_out($sformatf("frozen%0d", i), 4, 0, 0, 0);
      end
      bus.char_state = ST_LEFT;
      bus.vel_y      = '0;
      bus.frame_tick = 1'b1;
      @(posedge sys_clk);
      #1 bus.frame_tick = 1'b0;
      chk_out("tick_latency_hold", 4, 0, 0, 0);
      @(posedge sys_clk);
      #1 chk_out("tick_latency_upd", 2, 1, 0, 0);
      do_reset();
      tick(ST_LEFT, 0);
      tick(ST_JUMP, -5);
      tick(ST_FALL, 0);
      chk_out("rst_pre", 7, 1, 1, 1);
      tick(ST_FALL, 0);
      tick(ST_FALL, 0);
      #3 sys_rst_n = 1'b0;
      #1 chk_out("async_rst", 0, 0, 0, 0);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      bus.char_state = ST_LEFT;
      bus.vel_y      = '0;
      bus.frame_tick = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge sys_clk);
         #1 chk($sformatf("held_tick%0d id", c), 32'(bus.char_display_id), (c == 1) ? 0 : ((c - 2) < 8) ? 2 : 3);
      end
      bus.frame_tick = 1'b0;
      @(posedge sys_clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
